ring_sequencer: RTL

RING_SEQUENCER -- requirements
Module: ring_sequencer

---
 rtl/ring_seq_pkg.sv | 16 +
 rtl/ring_pos_encoder.sv | 25 ++
 rtl/ring_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/ring_seq_pkg.sv
// Shared constants and helpers for the ring sequencer: output encodings and
// the index-width rule used to size idx and load_idx.
package ring_seq_pkg;

  localparam int OUT_ONEHOT = 0;
  localparam int OUT_THERM  = 1;

  localparam int MIN_N = 2;
  localparam int MAX_N = 64;

  // A two-position ring still needs one index bit, so clog2 is floored at 1.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ring_pos_encoder.sv
// Combinational index-to-position encoder (one-hot or thermometer); its output
// is captured by the Out register in ring_sequencer.
module ring_pos_encoder
  import ring_seq_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int OUT_MODE = OUT_ONEHOT,
  localparam int IDX_W    = idx_width(N)
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [N-1:0]     o_out
);

  always_comb begin
    o_out = '0;
    for (int k = 0; k < N; k++) begin
      if (OUT_MODE == OUT_THERM) begin
        o_out[k] = (IDX_W'(k) <= i_idx);
      end else begin
        o_out[k] = (IDX_W'(k) == i_idx);
      end
    end
  end

endmodule

// File: rtl/ring_sequencer.sv
// Ring position sequencer: up/down stepping by 1 or 2 around N positions with
// load, crossing pulse, revolution counter and illegal-load flag, all registered.
module ring_sequencer
  import ring_seq_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int REV_W    = 8,
  parameter  int OUT_MODE = OUT_ONEHOT,
  localparam int IDX_W    = idx_width(N)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic             X,
  input  logic             step2,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  output logic [N-1:0]     Out,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic [REV_W-1:0] rev_cnt,
  output logic             load_err
);

  // Two spare bits keep idx + step and idx + N - step from overflowing.
  localparam int               SUM_W   = IDX_W + 2;
  localparam logic [SUM_W-1:0] N_S     = SUM_W'(N);
  localparam logic [N-1:0]     OUT_RST = N'(1);

  logic [IDX_W-1:0] r_idx;
  logic [N-1:0]     r_out;
  logic             r_wrap;
  logic [REV_W-1:0] r_rev;
  logic             r_load_err;

  logic [SUM_W-1:0] w_step;
  logic [SUM_W-1:0] w_cur;
  logic [SUM_W-1:0] w_up;
  logic [SUM_W-1:0] w_down;
  logic             w_cross;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_advance;
  logic [IDX_W-1:0] w_adv_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic [N-1:0]     w_out_next;

  // Any load, legal or not, blocks the advance so a bad load is a pure hold.
  always_comb begin
    w_step     = step2 ? SUM_W'(2) : SUM_W'(1);
    w_cur      = SUM_W'(r_idx);
    w_up       = w_cur + w_step;
    w_down     = w_cur + N_S - w_step;
    w_load_ok  = load && (SUM_W'(load_idx) < N_S);
    w_load_bad = load && !w_load_ok;
    w_advance  = !load && en;
    w_cross    = 1'b0;
    w_adv_idx  = r_idx;
    if (X) begin
      w_cross   = (w_up >= N_S);
      w_adv_idx = w_cross ? IDX_W'(w_up - N_S) : IDX_W'(w_up);
    end else begin
      w_cross   = (w_cur < w_step);
      w_adv_idx = w_cross ? IDX_W'(w_down) : IDX_W'(w_cur - w_step);
    end
    w_idx_next = r_idx;
    if (w_load_ok) begin
      w_idx_next = load_idx;
    end else if (w_advance) begin
      w_idx_next = w_adv_idx;
    end
  end

  ring_pos_encoder #(
    .N        (N),
    .OUT_MODE (OUT_MODE)
  ) u_enc (
    .i_idx (w_idx_next),
    .o_out (w_out_next)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_idx      <= '0;
      r_out      <= OUT_RST;
      r_wrap     <= 1'b0;
      r_rev      <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_idx      <= w_idx_next;
      r_out      <= w_out_next;
      r_wrap     <= w_advance && w_cross;
      r_load_err <= w_load_bad;
      if (w_load_ok) begin
        r_rev <= '0;
      end else if (w_advance && w_cross) begin
        r_rev <= r_rev + REV_W'(1);
      end
    end
  end

  assign Out      = r_out;
  assign idx      = r_idx;
  assign wrap     = r_wrap;
  assign rev_cnt  = r_rev;
  assign load_err = r_load_err;

endmodule
